// File: rtl/rx_word_fifo.sv
// rx_word_fifo: assembles received UART bytes into WORD_BYTES-wide words
// (selectable byte order), queues them in a show-ahead FIFO and hands them
// to the core with a valid/ready handshake. Flags dropped words (overflow)
// and discards stale partial words after an optional inter-byte timeout.
module rx_word_fifo #(
    parameter int WORD_BYTES     = 4,
    parameter int DEPTH_LOG2     = 3,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    flush,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    overflow,
    input  logic                    overflow_clear,
    output logic                    partial_drop
);
    localparam int W        = 8 * WORD_BYTES;
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_INT = WORD_BYTES - 1;
    localparam int TO_INT   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [IDX_W-1:0]    LAST_IDX   = LAST_INT[IDX_W-1:0];
    localparam logic [TO_W-1:0]     TO_LAST    = TO_INT[TO_W-1:0];
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

    // Word storage
    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;

    // Assembly state
    logic [IDX_W-1:0] idx_reg;
    logic [TO_W-1:0]  idle_reg;
    logic [W-1:0]     asm_reg;
    logic [W-1:0]     asm_next;
    logic [IDX_W-1:0] lane;
    logic             overflow_reg;

    // Handshake / control decode
    logic full;
    logic word_done;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_event;
    logic expire;

    // Byte lane targeted by the current byte index
    always_comb begin
        lane = BIG_ENDIAN ? (LAST_IDX - idx_reg) : idx_reg;
    end

    // Current word with the incoming byte merged into its lane
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign asm_next[8*gi +: 8] = (lane == IDX_W'(gi)) ? byte_in : asm_reg[8*gi +: 8];
        end
    endgenerate

    // Flush blocks both push and pop; a pop frees the slot for a push when full
    assign full       = (count_reg == FULL_COUNT);
    assign word_valid = (count_reg != '0);
    assign word_done  = byte_valid && (idx_reg == LAST_IDX);
    assign pop        = !flush && word_valid && word_ready;
    assign push_req   = !flush && word_done;
    assign push       = push_req && (!full || pop);
    assign ovf_event  = push_req && full && !pop;
    assign expire     = (TIMEOUT_CYCLES > 0) && !reset && !flush && !byte_valid &&
                        (idx_reg != '0) && (idle_reg == TO_LAST);

    assign partial_drop = expire;
    assign word_out     = word_valid ? mem[rd_ptr_reg] : '0;
    assign count        = count_reg;
    assign overflow     = overflow_reg;

    // FIFO storage: written only on an accepted push, contents need no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= asm_next;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    // Byte index and inter-byte idle counter; a byte always beats expiry
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            idx_reg  <= '0;
            idle_reg <= '0;
        end else if (byte_valid) begin
            idx_reg  <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            idle_reg <= '0;
        end else if (expire) begin
            idx_reg  <= '0;
            idle_reg <= '0;
        end else if ((TIMEOUT_CYCLES > 0) && (idx_reg != '0)) begin
            idle_reg <= idle_reg + 1'b1;
        end
    end

    // Partial word accumulator
    always_ff @(posedge CLK) begin
        if (reset) begin
            asm_reg <= '0;
        end else if (byte_valid && !flush) begin
            asm_reg <= asm_next;
        end
    end

    // Sticky overflow; a new overflow event wins over a clear request
    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (ovf_event) begin
            overflow_reg <= 1'b1;
        end else if (overflow_clear) begin
            overflow_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_word_fifo.sv
// Testbench for rx_word_fifo: two instances (32-bit big-endian with timeout,
// 16-bit little-endian without) share one input stream; a queue-style
// reference model per instance predicts every output each cycle, and
// directed steps check hand-computed values.
module tb_rx_word_fifo;
    localparam int FW = 1024;

    logic        CLK;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        flush;
    logic        word_ready;
    logic        overflow_clear;

    logic [31:0] a_word_out;
    logic        a_word_valid;
    logic [2:0]  a_count;
    logic        a_overflow;
    logic        a_partial_drop;

    logic [15:0] b_word_out;
    logic        b_word_valid;
    logic [3:0]  b_count;
    logic        b_overflow;
    logic        b_partial_drop;

    rx_word_fifo #(.WORD_BYTES(4), .DEPTH_LOG2(2), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(10)) dut_a (
        .CLK(CLK), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .flush(flush),
        .word_out(a_word_out), .word_valid(a_word_valid), .word_ready(word_ready),
        .count(a_count), .overflow(a_overflow), .overflow_clear(overflow_clear),
        .partial_drop(a_partial_drop)
    );

    rx_word_fifo #(.WORD_BYTES(2), .DEPTH_LOG2(3), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
        .CLK(CLK), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .flush(flush),
        .word_out(b_word_out), .word_valid(b_word_valid), .word_ready(word_ready),
        .count(b_count), .overflow(b_overflow), .overflow_clear(overflow_clear),
        .partial_drop(b_partial_drop)
    );

    always #5 CLK = ~CLK;

    // Reference model parameters per instance
    int unsigned wbp [2] = '{4, 2};
    int unsigned dep [2] = '{4, 8};
    bit          bep [2] = '{1'b1, 1'b0};
    int unsigned top [2] = '{10, 0};

    // Reference model state: words in arrival order, bytes of the partial word
    logic [63:0] fw     [2][FW];
    int          head   [2];
    int          tail   [2];
    logic [7:0]  pbytes [2][8];
    int          npb    [2];
    int          idle   [2];
    bit          ov     [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pd_count = 0;
    int last_pd_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] compose(input int n);
        logic [63:0] w;
        w = 64'd0;
        for (int k = 0; k < int'(wbp[n]); k++) begin
            if (bep[n]) w = (w << 8) | 64'(pbytes[n][k]);
            else        w = w | (64'(pbytes[n][k]) << (8 * k));
        end
        return w;
    endfunction

    task automatic check_model(input int n, input logic v, input logic [63:0] w,
                               input logic [63:0] c, input logic o, input logic pd);
        int          sz;
        logic [63:0] ew;
        bit          epd;
        sz  = tail[n] - head[n];
        ew  = (sz > 0) ? fw[n][head[n] % FW] : 64'd0;
        epd = !reset && !flush && !byte_valid && (top[n] > 0) && (npb[n] > 0) &&
              (idle[n] + 1 == int'(top[n]));
        chk($sformatf("d%0d_word_valid", n), 64'(v), 64'(sz > 0));
        chk($sformatf("d%0d_word_out", n), w, ew);
        chk($sformatf("d%0d_count", n), c, 64'(sz));
        chk($sformatf("d%0d_overflow", n), 64'(o), 64'(ov[n]));
        chk($sformatf("d%0d_partial_drop", n), 64'(pd), 64'(epd));
    endtask

    task automatic model_step(input int n);
        int          sz;
        bit          pop;
        bit          done;
        bit          ovf_evt;
        logic [63:0] w;
        sz = tail[n] - head[n];
        w = 64'd0;
        if (reset) begin
            head[n] = 0; tail[n] = 0; npb[n] = 0; idle[n] = 0; ov[n] = 1'b0;
        end else if (flush) begin
            head[n] = 0; tail[n] = 0; npb[n] = 0; idle[n] = 0;
            if (overflow_clear) ov[n] = 1'b0;
        end else begin
            pop = (sz > 0) && word_ready;
            done = 1'b0;
            ovf_evt = 1'b0;
            if (byte_valid) begin
                pbytes[n][npb[n]] = byte_in;
                npb[n]++;
                idle[n] = 0;
                if (npb[n] == int'(wbp[n])) begin
                    w = compose(n);
                    npb[n] = 0;
                    done = 1'b1;
                end
            end else if (npb[n] > 0) begin
                if ((top[n] > 0) && (idle[n] + 1 == int'(top[n]))) begin
                    npb[n] = 0;
                    idle[n] = 0;
                end else begin
                    idle[n]++;
                end
            end
            if (pop) begin
                $display("t=%0t dut%0d pop word=%0h", $time, n, fw[n][head[n] % FW]);
                head[n]++;
            end
            if (done) begin
                if ((sz < int'(dep[n])) || pop) begin
                    fw[n][tail[n] % FW] = w;
                    tail[n]++;
                end else begin
                    ovf_evt = 1'b1;
                    ov[n] = 1'b1;
                end
            end
            if (overflow_clear && !ovf_evt) ov[n] = 1'b0;
        end
    endtask

    // One clock cycle: check mid-cycle, advance the model, move past the edge
    task automatic cycle();
        #4;
        if (a_partial_drop) begin
            pd_count++;
            last_pd_cyc = cyc;
        end
        check_model(0, a_word_valid, 64'(a_word_out), 64'(a_count), a_overflow, a_partial_drop);
        check_model(1, b_word_valid, 64'(b_word_out), 64'(b_count), b_overflow, b_partial_drop);
        model_step(0);
        model_step(1);
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        cycle();
        byte_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    initial begin
        int          strobe_cyc;
        int          pd_before;
        logic [7:0]  kb;
        int          bv_pct;

        CLK = 1'b0;
        reset = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        flush = 1'b0;
        word_ready = 1'b0;
        overflow_clear = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_valid", 64'(a_word_valid), 64'd0);
        chk("rst_word", 64'(a_word_out), 64'd0);
        chk("rst_ovf", 64'(a_overflow), 64'd0);
        chk("rst_pdrop", 64'(a_partial_drop), 64'd0);

        // Big-endian assembly, one cycle latency
        send4(32'h12345678);
        chk("be_valid", 64'(a_word_valid), 64'd1);
        chk("be_word", 64'(a_word_out), 64'h12345678);
        chk("be_count", 64'(a_count), 64'd1);
        chk("le16_word", 64'(b_word_out), 64'h3412);
        chk("le16_count", 64'(b_count), 64'd2);
        word_ready = 1'b1;
        repeat (2) cycle();
        word_ready = 1'b0;
        chk("drain_a_valid", 64'(a_word_valid), 64'd0);
        chk("drain_a_word", 64'(a_word_out), 64'd0);
        chk("drain_b_count", 64'(b_count), 64'd0);

        // Little-endian 16-bit word, then timeout on the 2-byte partial in dut_a
        send_byte(8'hAB);
        send_byte(8'hCD);
        strobe_cyc = cyc - 1;
        chk("le_word", 64'(b_word_out), 64'hCDAB);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        chk("le_pop_valid", 64'(b_word_valid), 64'd0);
        chk("le_pop_word", 64'(b_word_out), 64'd0);
        chk("le_pop_count", 64'(b_count), 64'd0);
        pd_before = pd_count;
        repeat (11) cycle();
        chk("to_pulse_count", 64'(pd_count - pd_before), 64'd1);
        chk("to_pulse_cycle", 64'(last_pd_cyc), 64'(strobe_cyc + 10));
        send4(32'hDEADBEEF);
        chk("to_fresh_word", 64'(a_word_out), 64'hDEADBEEF);
        chk("to_fresh_count", 64'(a_count), 64'd1);
        word_ready = 1'b1;
        repeat (2) cycle();
        word_ready = 1'b0;

        // Overflow: five words into a depth-4 FIFO
        for (int k = 1; k <= 5; k++) send4(32'(k));
        chk("ovf_count", 64'(a_count), 64'd4);
        chk("ovf_flag", 64'(a_overflow), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", 64'(a_word_out), 64'(k));
            word_ready = 1'b1;
            cycle();
        end
        word_ready = 1'b0;
        chk("ovf_empty", 64'(a_count), 64'd0);
        overflow_clear = 1'b1;
        cycle();
        overflow_clear = 1'b0;
        chk("ovf_clear_a", 64'(a_overflow), 64'd0);
        chk("ovf_clear_b", 64'(b_overflow), 64'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_b_count", 64'(b_count), 64'd0);

        // Push and pop together while full
        for (int k = 1; k <= 4; k++) begin
            kb = 8'(k);
            send4({kb, kb, kb, kb});
        end
        chk("full_count", 64'(a_count), 64'd4);
        send_byte(8'h05);
        send_byte(8'h05);
        send_byte(8'h05);
        word_ready = 1'b1;
        send_byte(8'h05);
        word_ready = 1'b0;
        chk("pp_count", 64'(a_count), 64'd4);
        chk("pp_ovf", 64'(a_overflow), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            kb = 8'(k);
            chk("pp_order", 64'(a_word_out), 64'({kb, kb, kb, kb}));
            word_ready = 1'b1;
            cycle();
        end
        word_ready = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Flush with a byte in the same cycle; overflow survives
        for (int k = 1; k <= 5; k++) send4(32'h10101010 * k);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        chk("pre_flush_count", 64'(a_count), 64'd3);
        send_byte(8'h77);
        byte_in = 8'h99;
        byte_valid = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        byte_valid = 1'b0;
        chk("flush_count", 64'(a_count), 64'd0);
        chk("flush_valid", 64'(a_word_valid), 64'd0);
        chk("flush_word", 64'(a_word_out), 64'd0);
        chk("flush_ovf_kept", 64'(a_overflow), 64'd1);
        send4(32'h01020304);
        chk("post_flush_word", 64'(a_word_out), 64'h01020304);
        chk("post_flush_count", 64'(a_count), 64'd1);

        // Reset mid-word discards everything
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_count", 64'(a_count), 64'd0);
        chk("mid_rst_ovf", 64'(a_overflow), 64'd0);
        chk("mid_rst_b_count", 64'(b_count), 64'd0);
        send4(32'hCAFEBABE);
        chk("post_rst_word", 64'(a_word_out), 64'hCAFEBABE);
        chk("post_rst_b_word", 64'(b_word_out), 64'hFECA);
        chk("post_rst_b_count", 64'(b_count), 64'd2);

        // Randomized traffic against the reference model
        bv_pct = 60;
        for (int i = 0; i < 900; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       bv_pct = 70;
                    1:       bv_pct = 25;
                    default: bv_pct = 5;
                endcase
            end
            byte_in        = 8'($urandom);
            byte_valid     = ($urandom_range(0, 99) < bv_pct);
            word_ready     = ($urandom_range(0, 99) < 40);
            flush          = ($urandom_range(0, 199) == 0);
            overflow_clear = !flush && ($urandom_range(0, 29) == 0);
            reset          = ($urandom_range(0, 399) == 0);
            cycle();
        end
        reset = 1'b0;
        byte_valid = 1'b0;
        word_ready = 1'b0;
        flush = 1'b0;
        overflow_clear = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_word_fifo.md
Name: rx_word_fifo

Overview:
- Parametrised successor to the fixed 32-bit UART receive buffer.
- Sits between the UART byte receiver and the CPU core's UART-to-register path.
- Assembles WORD_BYTES received bytes into one word, with selectable byte order, and queues complete words in a DEPTH-entry FIFO.
- Delivers words to the core with a valid/ready handshake; reports overflow; discards stale partial words after an inter-byte timeout.

Parameters:
WORD_BYTES, 4, bytes per assembled word (1..8); word width W = 8*WORD_BYTES
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (1..10)
BIG_ENDIAN, 1, 1: first received byte lands in MSB; 0: first byte lands in LSB
TIMEOUT_CYCLES, 0, idle cycles after which a partial word is dropped; 0 disables the timeout

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high reset
byte_in  input  8  received byte, sampled when byte_valid=1
byte_valid  input  1  single-cycle strobe from the UART receiver
flush  input  1  synchronous clear of the FIFO and the partial word
word_out  output  W  FIFO head word; forced to 0 when word_valid=0
word_valid  output  1  FIFO non-empty
word_ready  input  1  consumer accepts head word when word_valid&word_ready
count  output  DEPTH_LOG2+1  number of words held (0..DEPTH)
overflow  output  1  sticky flag: a completed word was dropped because the FIFO was full
overflow_clear  input  1  clears overflow
partial_drop  output  1  one-cycle pulse when a partial word is discarded by timeout

Behaviour:
- Reset:
  - count=0, word_valid=0, word_out=0, overflow=0, partial_drop=0.
  - Byte index=0, timeout counter=0, read/write pointers=0.
  - Reset asserted mid-word or mid-transfer discards all state.
- Assembly:
  - Byte index k counts 0..WORD_BYTES-1 and increments on each byte_valid.
  - BIG_ENDIAN=1: byte k is placed at bits [W-1-8k -: 8]. BIG_ENDIAN=0: byte k is placed at bits [8k +: 8].
  - On byte k=WORD_BYTES-1 the word is complete and the index wraps to 0.
- Push and latency:
  - A completed word is pushed at the same clock edge that samples its last byte.
  - word_valid/word_out reflect it the following cycle (1-cycle latency from the last byte strobe).
- FIFO:
  - Show-ahead: word_out is always the head entry while count>0.
  - Pop on the edge where word_valid&word_ready; word_ready is ignored when empty.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - Valid when full, because the pop frees the slot first. When empty, only the push happens.
- Push while full with no pop:
  - The word is discarded and overflow is set.
  - FIFO contents and count are unchanged; the byte index still wraps to 0.
- overflow_clear:
  - Clears overflow next cycle.
  - If an overflow event occurs in the same cycle, set wins.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs only while byte index≠0 and resets to 0 on every byte_valid.
  - When it reaches TIMEOUT_CYCLES with no byte_valid that cycle: index←0, counter←0, partial_drop=1 for exactly one cycle. FIFO is untouched.
  - byte_valid in the expiry cycle takes priority: the byte is accepted and nothing is dropped.
- flush:
  - Next cycle: count=0, pointers=0, byte index=0, timeout counter=0.
  - A byte_valid or pop in the same cycle is ignored. overflow is unaffected.
- Priority: reset > flush > byte/push/pop > timeout.
- partial_drop is 0 except for the single expiry cycle.

Test Plan:
- Default parameters; bytes 0x12,0x34,0x56,0x78 with word_ready=0 -> one cycle after the 4th strobe: word_valid=1, word_out=0x12345678, count=1.
- BIG_ENDIAN=0, WORD_BYTES=2; bytes 0xAB,0xCD -> word_out=0xCDAB. Raise word_ready for 1 cycle -> word_valid=0, word_out=0, count=0.
- DEPTH_LOG2=2; push 5 words 0x00000001..0x00000005 with word_ready=0 -> count=4, overflow=1.
  - Popping all four yields 1,2,3,4.
  - overflow_clear -> overflow=0.
- Full FIFO (count=4) with word_ready=1 held in the cycle the 5th word completes -> count stays 4, overflow=0, and word 5 is delivered last.
- TIMEOUT_CYCLES=10; send 2 bytes, then idle 10 cycles -> partial_drop pulses once on the 10th idle cycle.
  - Next 4 bytes 0xDE,0xAD,0xBE,0xEF -> word_out=0xDEADBEEF.
- Three words queued plus a 1-byte partial, then flush (with byte_valid in the same cycle) -> count=0, word_valid=0.
  - The next 4 bytes form a fresh word.
  - overflow keeps its prior value.
